sw_cmd_scheduler: RTL

//  Front-end controller for the switch-driven state machine. Conditions raw
//  SW1..SW4 levels (2-flop sync + debounce), converts clean rising edges into

---
 rtl/fsm_ctrl_pkg.sv | 27 ++
 rtl/sw_debounce.sv | 54 +++++
 rtl/sw_cmd_scheduler.sv | 109 ++++++++++
 3 files changed

// File: rtl/fsm_ctrl_pkg.sv
// Purpose : shared scheduler state encodings and command bit indices, also used
//           by the downstream FSM to decode the one-hot command.
// Contents: IDLE/OFFER/HOLD state values, CMD_SW1..CMD_SW4 bit positions,
//           fixed-priority one-hot pick helper (SW1 highest).
package fsm_ctrl_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] OFFER = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam int CMD_SW1 = 0;
  localparam int CMD_SW2 = 1;
  localparam int CMD_SW3 = 2;
  localparam int CMD_SW4 = 3;

  // Lowest-index set bit wins, so SW1 always beats SW2..SW4.
  function automatic logic [3:0] pick_first(input logic [3:0] req);
    logic [3:0] g;
    g = 4'b0000;
    if (req[CMD_SW1])      g[CMD_SW1] = 1'b1;
    else if (req[CMD_SW2]) g[CMD_SW2] = 1'b1;
    else if (req[CMD_SW3]) g[CMD_SW3] = 1'b1;
    else if (req[CMD_SW4]) g[CMD_SW4] = 1'b1;
    return g;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Purpose : 2-flop synchronizer + counting debouncer for one raw switch; emits a
//           one-cycle rise pulse in the same cycle the debounced level goes 0->1.
// Latency : raw rise before edge k -> debounced level (and rise) at edge k+1+DEB_CYCLES.
// Backpressure: none, free-running; the pulse must be consumed the cycle it appears.
// Ports   : clk, rst (sync active-high), sw_raw (async level), rise (pulse out).
module sw_debounce
  import fsm_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_raw,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic             db;
  logic [CNT_W-1:0] cnt;
  logic             flip;

  // The level changes on the edge where the last required disagreeing sample
  // is seen; rise is decoded from the pre-edge values so it lines up with it.
  assign flip = (s2 != db) && (cnt == CNT_LAST);
  assign rise = flip & s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      db  <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= sw_raw;
      s2 <= s1;
      if (s2 != db) begin
        if (cnt == CNT_LAST) begin
          db  <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        // Any agreeing sample restarts the count.
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/sw_cmd_scheduler.sv
// Purpose : turns debounced SW1..SW4 rising edges into sticky requests and issues
//           them one at a time as a one-hot command with a fixed post-accept gap.
// Latency : request visible one edge after debounce; cmd_valid one edge later if IDLE.
// Backpressure: an offered command is held stable until cmd_ready; new edges keep
//           accumulating in pending, a repeat edge on a pending bit sets sticky ovf.
// Ports   : KEY0 clock, SW0 sync reset, SW1..SW4 raw switches, cmd_ready in;
//           cmd_valid, cmd[3:0], pending[3:0], ovf out.
module sw_cmd_scheduler
  import fsm_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int GAP_CYCLES = 2,
  parameter int CNT_W      = 3
) (
  input  logic       KEY0,
  input  logic       SW0,
  input  logic       SW1,
  input  logic       SW2,
  input  logic       SW3,
  input  logic       SW4,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [3:0] cmd,
  output logic [3:0] pending,
  output logic       ovf
);

  // With GAP_CYCLES==0 the HOLD state is never entered, so the load value is moot.
  localparam logic [CNT_W-1:0] GAP_LOAD =
    CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  logic [3:0]       sw_raw;
  logic [3:0]       rise;
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [3:0]       cmd_q;
  logic [CNT_W-1:0] gap_cnt;
  logic [3:0]       grant;
  logic             take;
  logic [3:0]       clr;

  assign sw_raw = {SW4, SW3, SW2, SW1};

  for (genvar i = 0; i < 4; i++) begin : g_deb
    sw_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .CNT_W      (CNT_W)
    ) u_deb (
      .clk    (KEY0),
      .rst    (SW0),
      .sw_raw (sw_raw[i]),
      .rise   (rise[i])
    );
  end

  assign grant = pick_first(pending);
  assign take  = (state == IDLE) && (|pending);
  assign clr   = take ? grant : 4'b0000;

  // State register
  always_ff @(posedge KEY0) begin
    if (SW0) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = (|pending) ? OFFER : IDLE;
      OFFER: begin
        if (cmd_ready) state_nxt = (GAP_CYCLES == 0) ? IDLE : HOLD;
        else           state_nxt = OFFER;
      end
      HOLD:    state_nxt = (gap_cnt == '0) ? IDLE : HOLD;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: cmd is forced to zero whenever nothing is offered.
  always_comb begin
    cmd_valid = 1'b0;
    cmd       = 4'b0000;
    if (state == OFFER) begin
      cmd_valid = 1'b1;
      cmd       = cmd_q;
    end
  end

  // Command latch, gap counter, request bookkeeping
  always_ff @(posedge KEY0) begin
    if (SW0) begin
      cmd_q   <= 4'b0000;
      gap_cnt <= '0;
      pending <= 4'b0000;
      ovf     <= 1'b0;
    end else begin
      if (take) cmd_q <= grant;
      if ((state == OFFER) && cmd_ready)
        gap_cnt <= GAP_LOAD;
      else if ((state == HOLD) && (gap_cnt != '0))
        gap_cnt <= gap_cnt - CNT_W'(1);
      // OR-ing rise after the clear lets a same-cycle new edge survive the clear.
      pending <= (pending & ~clr) | rise;
      if (|(rise & pending)) ovf <= 1'b1;
    end
  end

endmodule
